// File: rtl/alu_arb_if.sv
// ============================================================================
// Module      : alu_arb_if
// Description : Request/response/ALU bundle for the two-port ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arb_if #(
  parameter int XLEN = 32
);
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [5:0]        req_comp_sel_i;
  logic [1:0]        req_op_0_sel_i;
  logic [5:0]        req_op_1_sel_i;
  logic [2*XLEN-1:0] req_a_data_i;
  logic [2*XLEN-1:0] req_b_data_i;

  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready_i;
  logic [1:0]        rsp_comp_o;
  logic [2*XLEN-1:0] rsp_data_o;

  logic [2:0]        alu_comp_sel_o;
  logic              alu_op_0_sel_o;
  logic [2:0]        alu_op_1_sel_o;
  logic [XLEN-1:0]   alu_a_data_o;
  logic [XLEN-1:0]   alu_b_data_o;
  logic              alu_comp_i;
  logic [XLEN-1:0]   alu_data_i;

  // Port that won the most recent grant (observability of arbitration state).
  logic              last_grant_o;

  // Requesters, response consumers and the shared ALU all sit on the master side.
  modport master (
    output req_valid_i, req_comp_sel_i, req_op_0_sel_i, req_op_1_sel_i,
           req_a_data_i, req_b_data_i, rsp_ready_i, alu_comp_i, alu_data_i,
    input  req_ready_o, rsp_valid_o, rsp_comp_o, rsp_data_o,
           alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o,
           alu_a_data_o, alu_b_data_o, last_grant_o
  );

  modport slave (
    input  req_valid_i, req_comp_sel_i, req_op_0_sel_i, req_op_1_sel_i,
           req_a_data_i, req_b_data_i, rsp_ready_i, alu_comp_i, alu_data_i,
    output req_ready_o, rsp_valid_o, rsp_comp_o, rsp_data_o,
           alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o,
           alu_a_data_o, alu_b_data_o, last_grant_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_arb.sv
// ============================================================================
// Module      : alu_arb
// Description : Shares one combinational ALU between two requesters, with a
//               registered, backpressured response slot per port.
//               Define ALU_ARB_RR_EN for round-robin contention; otherwise
//               port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arb #(
  parameter int XLEN = 32
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  alu_arb_if.slave  bus
);

  logic [1:0]        w_elig;
  logic [1:0]        w_grant;
  logic              r_last_grant;
  logic [1:0]        r_rsp_valid;
  logic [1:0]        r_rsp_comp;
  logic [2*XLEN-1:0] r_rsp_data;

  // A slot being drained this cycle counts as free.
  assign w_elig = bus.req_valid_i & (~r_rsp_valid | bus.rsp_ready_i);

  always_comb begin
    w_grant = w_elig;
    if (&w_elig) begin
`ifdef ALU_ARB_RR_EN
      w_grant = r_last_grant ? 2'b01 : 2'b10;
`else
      w_grant = 2'b01;
`endif
    end
  end

  always_comb begin
    bus.alu_comp_sel_o = '0;
    bus.alu_op_0_sel_o = 1'b0;
    bus.alu_op_1_sel_o = '0;
    bus.alu_a_data_o   = '0;
    bus.alu_b_data_o   = '0;
    if (w_grant[0]) begin
      bus.alu_comp_sel_o = bus.req_comp_sel_i[2:0];
      bus.alu_op_0_sel_o = bus.req_op_0_sel_i[0];
      bus.alu_op_1_sel_o = bus.req_op_1_sel_i[2:0];
      bus.alu_a_data_o   = bus.req_a_data_i[XLEN-1:0];
      bus.alu_b_data_o   = bus.req_b_data_i[XLEN-1:0];
    end else if (w_grant[1]) begin
      bus.alu_comp_sel_o = bus.req_comp_sel_i[5:3];
      bus.alu_op_0_sel_o = bus.req_op_0_sel_i[1];
      bus.alu_op_1_sel_o = bus.req_op_1_sel_i[5:3];
      bus.alu_a_data_o   = bus.req_a_data_i[2*XLEN-1:XLEN];
      bus.alu_b_data_o   = bus.req_b_data_i[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last_grant <= 1'b1;
      r_rsp_valid  <= '0;
      r_rsp_comp   <= '0;
      r_rsp_data   <= '0;
    end else begin
      if (|w_grant) begin
        r_last_grant <= w_grant[1];
      end
      for (int n = 0; n < 2; n++) begin
        // A new grant wins over a same-cycle drain, so the slot stays full.
        if (w_grant[n]) begin
          r_rsp_valid[n]               <= 1'b1;
          r_rsp_comp[n]                <= bus.alu_comp_i;
          r_rsp_data[n*XLEN +: XLEN]   <= bus.alu_data_i;
        end else if (r_rsp_valid[n] && bus.rsp_ready_i[n]) begin
          r_rsp_valid[n]               <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready_o  = w_grant;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_comp_o   = r_rsp_comp;
  assign bus.rsp_data_o   = r_rsp_data;
  assign bus.last_grant_o = r_last_grant;

endmodule

`default_nettype wire

// File: doc/alu_arb.md
# alu_arb

Two-port arbiter that shares one combinational `alu` instance between two requesters in the hxd32 execute stage, e.g. the main issue path (port 0) and the iterative branch/address helper (port 1). Each cycle it grants at most one request, steers that request's operands and selects onto the ALU, and captures the ALU result into a per-port response register. Responses carry valid/ready backpressure.

## Interface
- `XLEN`, 32, datapath width.
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  2  request valid, bit n = port n.
- `req_ready_o`  out  2  request accepted this cycle (one-hot or zero).
- `req_comp_sel_i`  in  6  port n compare select at `[3n+:3]`.
- `req_op_0_sel_i`  in  2  port n sub/sra modifier.
- `req_op_1_sel_i`  in  6  port n operation select at `[3n+:3]`.
- `req_a_data_i`, `req_b_data_i`  in  2*XLEN  port n operands at `[n*XLEN+:XLEN]`.
- `rsp_valid_o`  out  2  response valid per port.
- `rsp_ready_i`  in  2  response consumed per port.
- `rsp_comp_o`  out  2  captured compare bit per port.
- `rsp_data_o`  out  2*XLEN  captured result per port.
- `alu_comp_sel_o`, `alu_op_0_sel_o`, `alu_op_1_sel_o`, `alu_a_data_o`, `alu_b_data_o`  out  3/1/3/XLEN/XLEN  drive shared ALU.
- `alu_comp_i`, `alu_data_i`  in  1/XLEN  shared ALU results.

## Operation
- Port n is eligible when `req_valid_i[n] && (!rsp_valid_o[n] || rsp_ready_i[n])`. A full response slot being drained in the same cycle still counts as free.
- Grant rules:
  - Only one port eligible: that port is granted.
  - Both ports eligible: the winner is set by the priority policy (see Configuration).
- `req_ready_o` equals the grant. It is combinational from valid and slot state. Requesters must not make valid depend on ready.
- ALU mux:
  - The granted port's fields are driven on the `alu_*_o` outputs.
  - With no grant, every `alu_*_o` is driven to 0.
- On the clock edge with grant n:
  - `rsp_valid_o[n]` becomes 1.
  - `rsp_comp_o[n]` captures `alu_comp_i` and `rsp_data_o[n*XLEN+:XLEN]` captures `alu_data_i`.
  - `last_grant` becomes n.
- On the clock edge with `rsp_valid_o[n] && rsp_ready_i[n]` and no grant to n: `rsp_valid_o[n]` becomes 0. Data holds its last value.
- Simultaneous drain and new grant on the same port: valid stays 1 and the data is replaced.
- The ungranted port's response register is unaffected.
- Internal state: `last_grant` (1 bit) and two response registers. There is no other FSM.

## Timing
- Reset values:
  - `rsp_valid_o`=0, `rsp_comp_o`=0, `rsp_data_o`=0.
  - `last_grant`=1, so port 0 wins the first contention.
- Reset is asynchronous. A mid-operation reset drops all pending responses, and in-flight accepted requests are lost.
- Latency: a response is valid the cycle after acceptance.
- Throughput: one grant per cycle total. Each port can sustain one per cycle while its consumer keeps `rsp_ready_i` high.
- Response data is stable while `rsp_valid_o[n]` is 1 and not consumed.
- Combinational paths: `req_*` → `alu_*_o` → `alu_*_i` → response flops. The whole path is single-cycle.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. On contention the port `!last_grant` wins, so contending requesters alternate every cycle.
- `ALU_ARB_RR_EN` undefined: fixed priority. On contention port 0 always wins. `last_grant` is still maintained but not used for arbitration.

## Test plan
- Reset: assert `rst_n_i`=0 mid-transfer → `rsp_valid_o`=2'b00, `rsp_data_o`=0, and `req_ready_o`=0 while no valid is asserted.
- Single port: port 0 issues ADD with a=5, b=7 and `rsp_ready_i`=1 → `req_ready_o`=2'b01 that cycle; next cycle `rsp_valid_o[0]`=1 and data=12.
- Contention, 4 cycles, both ports valid every cycle:
  - Port 0 issues SUB 10−3; port 1 issues BLT with −1, 1.
  - With RR: grants 01, 10, 01, 10; port 1 sees `rsp_comp_o[1]`=1 and port 0 sees data=7.
  - Without RR: grant 01 on every cycle.
- Backpressure: port 1 response full with `rsp_ready_i[1]`=0 and port 1 valid → `req_ready_o[1]`=0 and port 0 is granted. Raise `rsp_ready_i[1]` → port 1 is granted that same cycle.
- Simultaneous drain and refill: port 0 issues SRA back-to-back (0x80000000 >> 4 → 0xF8000000, then XOR 0xF0 ^ 0x0F → 0xFF) with ready held high → `rsp_valid_o[0]` stays 1 and data updates each cycle.
- Idle: no `req_valid_i` → all `alu_*_o` are 0 and response registers are unchanged.
